// File: rtl/stream_burst_source_pkg.sv
// Shared definitions for the stream burst source.
// Holds the FSM state encoding and the default widths used by the
// interface and the top module:
//   DW_DEFAULT - beat data width
//   LW_DEFAULT - burst length / beat counter width
//   GW_DEFAULT - idle gap counter width
package stream_burst_source_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int LW_DEFAULT = 8;
  localparam int GW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/stream_burst_source_if.sv
// Valid/ready stream link between a producer and a consumer.
// Signals:
//   valid_out - beat valid, driven by the producer
//   data_out  - beat data, driven by the producer
//   ready_in  - consumer ready, driven by the consumer
// Modports:
//   master - producing end (drives valid_out/data_out, reads ready_in)
//   slave  - consuming end (reads valid_out/data_out, drives ready_in)
interface stream_burst_source_if
  import stream_burst_source_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          ready_in;

  modport master (
    output valid_out,
    output data_out,
    input  ready_in
  );

  modport slave (
    input  valid_out,
    input  data_out,
    output ready_in
  );

endinterface

// File: rtl/stream_burst_source.sv
// Valid/ready burst transmitter.
// A start command in IDLE launches a burst of cmd_len beats carrying
// cmd_base, cmd_base+cmd_step, cmd_base+2*cmd_step, ... (mod 2^DW), with
// cmd_gap idle cycles after every non-final beat. All outputs come
// straight from flops, so ready_in only influences next-state logic.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   start     - command strobe, only looked at in IDLE
//   cmd_len   - number of beats (0 gives an empty burst)
//   cmd_base  - first beat value
//   cmd_step  - per-beat increment
//   cmd_gap   - idle cycles after each non-final beat
//   stream    - master side of the valid/ready link
//   busy      - burst in progress
//   done      - one-cycle pulse after the burst finishes
//   beat_cnt  - beats transferred in the current/last burst
module stream_burst_source
  import stream_burst_source_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int LW = LW_DEFAULT,
  parameter int GW = GW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LW-1:0]        cmd_len,
  input  logic [DW-1:0]        cmd_base,
  input  logic [DW-1:0]        cmd_step,
  input  logic [GW-1:0]        cmd_gap,
  stream_burst_source_if.master stream,
  output logic                 busy,
  output logic                 done,
  output logic [LW-1:0]        beat_cnt
);

  state_t        state, state_n;
  logic          valid_q, valid_n;
  logic [DW-1:0] data_q, data_n;
  logic          busy_n, done_n;
  logic [LW-1:0] beat_n;
  logic [LW-1:0] len_q, len_n;
  logic [DW-1:0] step_q, step_n;
  logic [GW-1:0] gap_q, gap_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          xfer;
  logic [LW-1:0] beat_inc;

  assign stream.valid_out = valid_q;
  assign stream.data_out  = data_q;

  assign xfer     = valid_q && stream.ready_in;
  assign beat_inc = beat_cnt + LW'(1);

  // Register every piece of state, including the outputs, so that the
  // stream side never sees a combinational path from ready_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      data_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      beat_cnt <= '0;
      len_q    <= '0;
      step_q   <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      valid_q  <= valid_n;
      data_q   <= data_n;
      busy     <= busy_n;
      done     <= done_n;
      beat_cnt <= beat_n;
      len_q    <= len_n;
      step_q   <= step_n;
      gap_q    <= gap_n;
      gap_cnt  <= gap_cnt_n;
    end
  end

  // Next-state and next-output logic. Everything holds by default; a
  // stall in SEND is therefore simply "no transfer, nothing changes".
  always_comb begin
    state_n   = state;
    valid_n   = valid_q;
    data_n    = data_q;
    busy_n    = busy;
    beat_n    = beat_cnt;
    len_n     = len_q;
    step_n    = step_q;
    gap_n     = gap_q;
    gap_cnt_n = gap_cnt;

    unique case (state)
      IDLE: begin
        // The command is captured here so later cmd_* changes cannot
        // disturb a running burst.
        if (start) begin
          beat_n = '0;
          len_n  = cmd_len;
          step_n = cmd_step;
          gap_n  = cmd_gap;
          if (cmd_len != '0) begin
            busy_n  = 1'b1;
            valid_n = 1'b1;
            data_n  = cmd_base;
            state_n = SEND;
          end else begin
            state_n = DONE;
          end
        end
      end

      SEND: begin
        if (xfer) begin
          beat_n = beat_inc;
          if (beat_inc == len_q) begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            state_n = DONE;
          end else if (gap_q == '0) begin
            data_n = data_q + step_q;
          end else begin
            // Advance the data now; it is only presented again when
            // valid_out rises at the end of the gap.
            valid_n   = 1'b0;
            data_n    = data_q + step_q;
            gap_cnt_n = gap_q;
            state_n   = GAP;
          end
        end
      end

      GAP: begin
        // Loaded with the gap length, so valid_out stays low for exactly
        // that many cycles before re-asserting.
        gap_cnt_n = gap_cnt - GW'(1);
        if (gap_cnt == GW'(1)) begin
          valid_n = 1'b1;
          state_n = SEND;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // done is the registered image of being in DONE, one cycle long.
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_stream_burst_source.sv
// Self-checking bench for stream_burst_source.
// A behavioural model tracks each burst as a list of expected beat values
// (base + k*step mod 2^DW), the number of beats already delivered and the
// idle cycles still owed after a non-final beat, then compares the DUT's
// registered outputs against it every cycle.
module tb_stream_burst_source;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_base = '0;
  logic [DW-1:0] cmd_step = '0;
  logic [GW-1:0] cmd_gap = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_cnt;

  int checks = 0;
  int failures = 0;

  stream_burst_source_if #(.DW(DW)) stream ();

  stream_burst_source #(
    .DW(DW),
    .LW(LW),
    .GW(GW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd_len (cmd_len),
    .cmd_base(cmd_base),
    .cmd_step(cmd_step),
    .cmd_gap (cmd_gap),
    .stream  (stream),
    .busy    (busy),
    .done    (done),
    .beat_cnt(beat_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Run one complete burst and check it cycle by cycle against the model.
  // ready_in is random with probability ready_pct and forced low during
  // cycles stall_lo..stall_hi (cycle 1 is the one after the start edge).
  // With noise set, start and cmd_* are scrambled while the burst runs.
  task automatic applyStimulus(input int len, input logic [DW-1:0] base,
                               input logic [DW-1:0] step, input int gap,
                               input int ready_pct, input int stall_lo,
                               input int stall_hi, input bit noise);
    int            xfers = 0;
    int            idle_left = 0;
    int            cyc = 0;
    bit            done_seen = 1'b0;
    bit            prev_stall = 1'b0;
    bit            exp_valid;
    bit            rdy;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp_data;

    cmd_len  = LW'(len);
    cmd_base = base;
    cmd_step = step;
    cmd_gap  = GW'(gap);
    start    = 1'b1;
    tick();
    start = 1'b0;

    while (!done_seen && cyc < 4000) begin
      cyc++;
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        cmd_len  = LW'($urandom);
        cmd_base = DW'($urandom);
        cmd_step = DW'($urandom);
        cmd_gap  = GW'($urandom);
      end

      exp_valid = (xfers < len) && (idle_left == 0);
      exp_data  = base + DW'(xfers) * step;
      checkOutput("valid", 32'(stream.valid_out), 32'(exp_valid));
      if (exp_valid) checkOutput("data", 32'(stream.data_out), 32'(exp_data));
      checkOutput("busy", 32'(busy), 32'(xfers < len));
      checkOutput("beat_cnt", 32'(beat_cnt), 32'(xfers));
      checkOutput("done", 32'(done), 32'(xfers == len));
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(stream.valid_out), 32'd1);
        checkOutput("hold_data", 32'(stream.data_out), 32'(prev_data));
      end

      rdy = ($urandom_range(0, 99) < ready_pct) && !(cyc >= stall_lo && cyc <= stall_hi);
      stream.ready_in = rdy;
      prev_stall = stream.valid_out && !rdy;
      prev_data  = stream.data_out;

      if (xfers == len) begin
        done_seen = 1'b1;
      end else begin
        if (exp_valid && rdy) begin
          xfers++;
          if (xfers < len) idle_left = gap;
        end else if (idle_left > 0) begin
          idle_left--;
        end
        tick();
      end
    end
    checkOutput("burst_completed", 32'(done_seen), 32'd1);

    // Leave DONE; any start raised in the DONE cycle must be ignored.
    tick();
    start = 1'b0;
    stream.ready_in = 1'($urandom_range(0, 1));
    checkOutput("post_valid", 32'(stream.valid_out), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_done", 32'(done), 32'd0);
    checkOutput("post_beat_cnt", 32'(beat_cnt), 32'(len));
  endtask

  initial begin
    stream.ready_in = 1'b0;
    $display("[TB] starting stream_burst_source bench");

    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_valid", 32'(stream.valid_out), 32'd0);
    checkOutput("reset_data", 32'(stream.data_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_beat_cnt", 32'(beat_cnt), 32'd0);

    $display("[TB] back-to-back burst");
    applyStimulus(4, 8'h10, 8'h01, 0, 100, 0, 0, 1'b0);

    $display("[TB] backpressure burst");
    applyStimulus(3, 8'hA0, 8'h10, 0, 100, 1, 3, 1'b0);

    $display("[TB] gap burst");
    applyStimulus(3, 8'h40, 8'h05, 2, 100, 0, 0, 1'b0);

    $display("[TB] wrap and zero length");
    applyStimulus(3, 8'hFE, 8'h01, 0, 100, 0, 0, 1'b0);
    applyStimulus(0, 8'h77, 8'h01, 0, 100, 0, 0, 1'b0);

    $display("[TB] start and command changes while busy");
    applyStimulus(5, 8'h30, 8'h07, 1, 70, 0, 0, 1'b1);
    applyStimulus(4, 8'hC8, 8'h21, 0, 100, 0, 0, 1'b1);

    $display("[TB] reset in the middle of a stall");
    cmd_len  = 8'd6;
    cmd_base = 8'h55;
    cmd_step = 8'h02;
    cmd_gap  = 4'd0;
    start    = 1'b1;
    stream.ready_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stream.ready_in = 1'b0;
    tick();
    checkOutput("stall_valid", 32'(stream.valid_out), 32'd1);
    checkOutput("stall_data", 32'(stream.data_out), 32'h59);
    checkOutput("stall_beat_cnt", 32'(beat_cnt), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_valid", 32'(stream.valid_out), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_beat_cnt", 32'(beat_cnt), 32'd0);
    stream.ready_in = 1'b1;
    tick();
    tick();
    checkOutput("abort_no_done", 32'(done), 32'd0);
    checkOutput("abort_idle_valid", 32'(stream.valid_out), 32'd0);

    $display("[TB] clean burst after reset");
    applyStimulus(3, 8'h01, 8'h01, 0, 100, 0, 0, 1'b0);

    $display("[TB] long burst with random ready");
    applyStimulus(255, DW'($urandom), 8'h03, 0, 50, 0, 0, 1'b0);

    $display("[TB] random bursts");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(int'($urandom_range(0, 20)), DW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(40, 100)),
                    0, 0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
